// File: rtl/inst_fetch_queue_pkg.sv
// Shared CPU definitions used by the fetch queue: instruction width, decoded field positions,
// and the queue entry and request tag types.
package inst_fetch_queue_pkg;
   localparam int XLEN       = 32;
   localparam int INST_W     = 32;
   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_W   = 7;
   localparam int FUNCT3_LSB = 12;
   localparam int FUNCT3_W   = 3;
   localparam int FUNCT7_LSB = 25;
   localparam int FUNCT7_W   = 7;

   typedef logic [INST_W-1:0] inst_t;
   typedef logic [XLEN-1:0]   addr_t;

   typedef struct packed {
      addr_t pc;
      inst_t inst;
   } fetch_entry_t;

   typedef struct packed {
      logic  valid;
      logic  epoch;
      addr_t pc;
   } fetch_tag_t;

   function automatic logic [OPCODE_W-1:0] opcode_of(input inst_t inst);
      return inst[OPCODE_LSB +: OPCODE_W];
   endfunction

   function automatic logic [FUNCT3_W-1:0] funct3_of(input inst_t inst);
      return inst[FUNCT3_LSB +: FUNCT3_W];
   endfunction

   function automatic logic [FUNCT7_W-1:0] funct7_of(input inst_t inst);
      return inst[FUNCT7_LSB +: FUNCT7_W];
   endfunction
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bundle: pcControl request, imem read port, and the issue port toward the
// reservation stations. The queue itself uses the slave modport.
interface inst_fetch_queue_if;
   import inst_fetch_queue_pkg::*;

   addr_t                pc;
   logic                 pcValid;
   logic                 flush;
   logic                 fetchReady;
   addr_t                imemAddr;
   logic                 imemReq;
   inst_t                imemData;
   logic                 issueReady;
   logic                 instValid;
   inst_t                instruction;
   addr_t                instPc;
   logic [OPCODE_W-1:0]  operatorType;
   logic [FUNCT3_W-1:0]  operatorSubType;
   logic [FUNCT7_W-1:0]  operatorFlag;

   modport slave (
      input  pc, pcValid, flush, imemData, issueReady,
      output fetchReady, imemAddr, imemReq, instValid, instruction, instPc,
             operatorType, operatorSubType, operatorFlag
   );

   modport master (
      output pc, pcValid, flush, imemData, issueReady,
      input  fetchReady, imemAddr, imemReq, instValid, instruction, instPc,
             operatorType, operatorSubType, operatorFlag
   );
endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// fetch_fifo: DEPTH-entry in-order instruction storage with wrap-around pointers and an
// occupancy count; clear empties it in one cycle.
module fetch_fifo
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  fetch_entry_t           wr_data,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         assert (!(push && count_q == FULL_CNT));
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clock) begin
      if (push && !clear) mem_q[wr_ptr_q] <= wr_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues imem reads, tags each with a redirect epoch, and queues returns
// in order for issue. Define FETCH_BYPASS_EN to forward a return straight to issue when empty.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int MEM_LAT = 1
) (
   input logic               clock,
   input logic               reset,
   inst_fetch_queue_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int OCC_W = 6;

   fetch_tag_t         tag_q [MEM_LAT];
   fetch_tag_t         tag_d [MEM_LAT];
   logic               epoch_q;
   logic [MEM_LAT-1:0] live;
   logic [OCC_W-1:0]   inflight;
   logic [CNT_W-1:0]   count;
   logic               empty;
   logic               fetch_ready, req, ret_ok, push, pop, bypass, inst_valid;
   fetch_entry_t       head, wr_entry, shown;

   generate
      for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_live
         assign live[gi] = tag_q[gi].valid && (tag_q[gi].epoch == epoch_q);
      end
   endgenerate

   assign inflight    = OCC_W'($countones(live));
   assign fetch_ready = !reset && !bus.flush && ((OCC_W'(count) + inflight) < OCC_W'(DEPTH));
   assign req         = bus.pcValid && fetch_ready;
   assign ret_ok      = live[MEM_LAT-1] && !bus.flush;
   assign wr_entry    = '{pc: tag_q[MEM_LAT-1].pc, inst: bus.imemData};

`ifdef FETCH_BYPASS_EN
   assign bypass = ret_ok && empty && bus.issueReady;
`else
   assign bypass = 1'b0;
`endif
   assign push = ret_ok && !bypass;
   assign pop  = !empty && bus.issueReady && !bus.flush;

   // Clearing valids on flush covers back-to-back flushes, where a one-bit epoch alone could alias.
   always_comb begin
      tag_d[0] = '{valid: req, epoch: epoch_q, pc: bus.pc};
      for (int i = 1; i < MEM_LAT; i++) tag_d[i] = tag_q[i-1];
      if (bus.flush) begin
         for (int i = 0; i < MEM_LAT; i++) tag_d[i].valid = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         epoch_q <= 1'b0;
         for (int i = 0; i < MEM_LAT; i++) tag_q[i] <= '0;
      end else begin
         if (bus.flush) epoch_q <= ~epoch_q;
         tag_q <= tag_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fetch_fifo (
      .clock   (clock),
      .reset   (reset),
      .clear   (bus.flush),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_entry),
      .head    (head),
      .count   (count),
      .empty   (empty)
   );

   assign inst_valid = !empty || bypass;
   assign shown      = inst_valid ? (bypass ? wr_entry : head) : '0;

   assign bus.fetchReady      = fetch_ready;
   assign bus.imemReq         = req;
   assign bus.imemAddr        = req ? bus.pc : '0;
   assign bus.instValid       = inst_valid;
   assign bus.instruction     = shown.inst;
   assign bus.instPc          = shown.pc;
   assign bus.operatorType    = opcode_of(shown.inst);
   assign bus.operatorSubType = funct3_of(shown.inst);
   assign bus.operatorFlag    = funct7_of(shown.inst);
endmodule
